regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (load-unit result).
- Arbitration is round-robin. The write command is registered before it reaches the register file.
- Keeps a per-register pending (busy) scoreboard so issue logic can detect read-after-write hazards.
- Sits between the execute/memory stages and the register file's WriteEn/WriteAddr/WriteData inputs.

Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- NREG, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- a_valid  in  1  port A has a writeback request
- a_addr  in  ADDR_W  port A destination register
- a_data  in  DATA_W  port A result
- a_ready  out  1  port A request accepted this cycle
- b_valid  in  1  port B has a writeback request
- b_addr  in  ADDR_W  port B destination register
- b_data  in  DATA_W  port B result
- b_ready  out  1  port B request accepted this cycle
- iss_valid  in  1  instruction with a destination register issued this cycle
- iss_addr  in  ADDR_W  destination of the issued instruction
- WriteEn  out  1  register file write enable (registered)
- WriteAddr  out  ADDR_W  register file write address (registered)
- WriteData  out  DATA_W  register file write data (registered)
- busy  out  NREG  scoreboard; bit r=1 means a write to register r is outstanding
- wb_idle  out  1  no request pending on either port and WriteEn low

Behaviour:
- Reset (rst=1 at a clock edge):
  - WriteEn=0, WriteAddr=0, WriteData=0, busy=0.
  - Round-robin pointer set to favour A.
  - a_ready=b_ready=0 while rst is high.
  - rst mid-operation discards the pending output write and all busy bits.
- Arbitration (combinational ready, one grant per cycle):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the port the pointer favours.
  - The pointer moves to favour the other port after any grant. A port that keeps requesting therefore waits at most one cycle.
  - a_ready and b_ready are never high together.
  - a_ready/b_ready never depend on WriteEn; the output stage accepts every cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - Requesters hold addr and data stable while valid && !ready.
  - A requester must not drop valid before it is accepted.
- Latency:
  - A transfer in cycle N gives WriteEn=1, WriteAddr/WriteData = granted addr/data, in cycle N+1.
  - The register file commits at the end of cycle N+1.
  - No transfer in cycle N gives WriteEn=0 in N+1. WriteAddr and WriteData hold their previous values.
- Register x0:
  - A transfer with addr=0 is accepted (ready=1) but yields WriteEn=0 in N+1.
  - iss_valid with iss_addr=0 is ignored; busy[0] is always 0.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets busy[iss_addr] at the next edge.
  - WriteEn=1 clears busy[WriteAddr] at the end of that cycle, coinciding with the register file commit. A reader therefore never sees busy=0 before the data is readable.
  - Set and clear of the same register at the same edge: set wins, since a new producer is pending.
  - Set and clear of different registers at the same edge: both take effect.
  - Re-issue to an already-busy register: the bit stays 1 and is cleared by the next write to it. Ordering of multiple outstanding producers is the issue logic's responsibility.
- wb_idle = !a_valid && !b_valid && !WriteEn.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, WriteEn=0, busy=0, Write* outputs=0. Then release rst with both valid -> A is granted first.
- Single port: a_valid=1, a_addr=5, a_data=32'h0000_0005 in cycle N -> a_ready=1 in N; WriteEn=1, WriteAddr=5, WriteData=32'h5 in N+1; WriteEn=0 in N+2.
- Contention:
  - Stimulus: A requests (6, 32'h4) and B requests (7, 32'h9), both held continuously.
  - Required: grants alternate A, B, A, B with never both ready.
  - Required: writes appear as (6,4), (7,9), … one cycle after each grant.
- x0 write: b_valid=1, b_addr=0, b_data=32'hDEAD_BEEF -> b_ready=1, WriteEn stays 0 next cycle, busy[0]=0.
- Scoreboard:
  - Stimulus: iss 12 at cycle 0, then A writes reg 12 at cycle 3.
  - Required: busy[12]=1 from cycle 1 through cycle 4; WriteEn=1 at cycle 4; busy[12]=0 from cycle 5.
  - Stimulus: iss 12 again in cycle 4 (same edge as the clear).
  - Required: busy[12] remains 1.
- Reset mid-write: A is granted in cycle N and rst=1 in cycle N+1 -> WriteEn=0 from cycle N+2, all busy bits 0, and the pointer favours A.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers, the issue stage and the
// register file write port. The master side is the pipeline, the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;

  logic              WriteEn;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [NREG-1:0]   busy;
  logic              wb_idle;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output iss_valid, iss_addr,
    input  WriteEn, WriteAddr, WriteData, busy, wb_idle
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  iss_valid, iss_addr,
    output WriteEn, WriteAddr, WriteData, busy, wb_idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load unit (B), with a registered write command and a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } rr_e;

  rr_e               rr_q, rr_d;
  logic              grant_a, grant_b;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  // Grant and next write command; readiness never looks at the output stage.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (!rst) begin
      if (bus.a_valid && (!bus.b_valid || rr_q == FAV_A)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end

    if (grant_a) begin
      rr_d    = FAV_B;
      we_d    = |bus.a_addr;
      waddr_d = bus.a_addr;
      wdata_d = bus.a_data;
    end else if (grant_b) begin
      rr_d    = FAV_A;
      we_d    = |bus.b_addr;
      waddr_d = bus.b_addr;
      wdata_d = bus.b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= FAV_A;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  // Clear lands with the register file commit; a same-edge reissue keeps the bit set.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_w;
        logic clr_w;
        assign set_w      = bus.iss_valid && (bus.iss_addr == ADDR_W'(gi));
        assign clr_w      = we_q && (waddr_q == ADDR_W'(gi));
        assign busy_d[gi] = set_w | (busy_q[gi] & ~clr_w);
      end
    end
  endgenerate

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.WriteEn   = we_q;
  assign bus.WriteAddr = waddr_q;
  assign bus.WriteData = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.wb_idle   = !bus.a_valid && !bus.b_valid && !we_q;

endmodule
